// File: rtl/iter_alu.sv
`default_nettype none
// ============================================================================
// Module   : iter_alu
// Brief    : Registered EX-stage ALU with valid/ready handshake and iterative
//            signed/unsigned multiply and divide into HI/LO.
// Revision : 1.0  initial release
// ============================================================================
module iter_alu #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      OP,
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] F,
  output logic [SIZE-1:0] HI,
  output logic [SIZE-1:0] LO,
  output logic            ZF,
  output logic            CF,
  output logic            OF,
  output logic            SF,
  output logic            PF,
  output logic            DZ
);

  localparam int SHW = $clog2(SIZE);
  localparam int M   = SIZE - 1;

  localparam logic [3:0] c_OP_AND  = 4'b0000;
  localparam logic [3:0] c_OP_OR   = 4'b0001;
  localparam logic [3:0] c_OP_XOR  = 4'b0010;
  localparam logic [3:0] c_OP_NOR  = 4'b0011;
  localparam logic [3:0] c_OP_ADD  = 4'b0100;
  localparam logic [3:0] c_OP_SUB  = 4'b0101;
  localparam logic [3:0] c_OP_SLT  = 4'b0110;
  localparam logic [3:0] c_OP_SLL  = 4'b0111;
  localparam logic [3:0] c_OP_SLTU = 4'b1000;
  localparam logic [3:0] c_OP_SRL  = 4'b1001;
  localparam logic [3:0] c_OP_SRA  = 4'b1010;

  localparam logic [SHW:0] c_CNT_END = (SHW+1)'(SIZE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_BUSY = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  logic [3:0]      r_op;
  logic [SIZE-1:0] r_a;
  logic [SIZE-1:0] r_b;
  logic [SIZE-1:0] r_m;
  logic [SIZE-1:0] r_wh;
  logic [SIZE-1:0] r_wl;
  logic [SHW:0]    r_cnt;
  logic [SIZE-1:0] r_f;
  logic [SIZE-1:0] r_hi;
  logic [SIZE-1:0] r_lo;
  logic            r_zf, r_cf, r_of, r_sf, r_pf, r_dz;
  logic            r_ovld;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_ovld;
  assign F         = r_f;
  assign HI        = r_hi;
  assign LO        = r_lo;
  assign ZF        = r_zf;
  assign CF        = r_cf;
  assign OF        = r_of;
  assign SF        = r_sf;
  assign PF        = r_pf;
  assign DZ        = r_dz;

  // Magnitudes of the incoming operands, used to seed the iterative unit.
  logic [SIZE-1:0] w_am;
  logic [SIZE-1:0] w_bm;
  assign w_am = (OP[0] & A[M]) ? (~A + 1'b1) : A;
  assign w_bm = (OP[0] & B[M]) ? (~B + 1'b1) : B;

  logic [SHW-1:0] w_sh;
  logic [SIZE:0]  w_add;
  logic [SIZE:0]  w_sub;
  logic [SIZE:0]  w_sll;
  assign w_sh  = r_a[SHW-1:0];
  assign w_add = {1'b0, r_a} + {1'b0, r_b};
  assign w_sub = {1'b0, r_a} - {1'b0, r_b};
  // Bit SIZE of the widened shift is B[SIZE-shamt], i.e. the last bit out.
  assign w_sll = {1'b0, r_b} << w_sh;

  logic [SIZE-1:0] w_f;
  logic            w_cf;
  logic            w_of;
  logic            w_rsv;

  always_comb begin
    w_f   = '0;
    w_cf  = 1'b0;
    w_of  = 1'b0;
    w_rsv = 1'b0;
    case (r_op)
      c_OP_AND:  w_f = r_a & r_b;
      c_OP_OR:   w_f = r_a | r_b;
      c_OP_XOR:  w_f = r_a ^ r_b;
      c_OP_NOR:  w_f = ~(r_a | r_b);
      c_OP_ADD: begin
        w_f  = w_add[SIZE-1:0];
        w_cf = w_add[SIZE];
        w_of = (r_a[M] == r_b[M]) && (w_add[M] != r_a[M]);
      end
      c_OP_SUB: begin
        w_f  = w_sub[SIZE-1:0];
        w_cf = w_sub[SIZE];
        w_of = (r_a[M] != r_b[M]) && (w_sub[M] != r_a[M]);
      end
      c_OP_SLT:  w_f = {{(SIZE-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      c_OP_SLL: begin
        w_f  = w_sll[SIZE-1:0];
        w_cf = w_sll[SIZE];
      end
      c_OP_SLTU: w_f = {{(SIZE-1){1'b0}}, (r_a < r_b)};
      c_OP_SRL:  w_f = r_b >> w_sh;
      c_OP_SRA:  w_f = $unsigned($signed(r_b) >>> w_sh);
      default:   w_rsv = 1'b1;
    endcase
  end

  // One shift-add (multiply) or restoring-subtract (divide) step.
  logic [SIZE:0] w_madd;
  logic [SIZE:0] w_msum;
  logic [SIZE:0] w_rsh;
  logic [SIZE:0] w_rdif;
  assign w_madd = {1'b0, r_wh} + {1'b0, r_m};
  assign w_msum = r_wl[0] ? w_madd : {1'b0, r_wh};
  assign w_rsh  = {r_wh, r_wl[SIZE-1]};
  assign w_rdif = w_rsh - {1'b0, r_m};

  logic [2*SIZE-1:0] w_prod_n;
  logic              w_neg_q;
  logic              w_neg_r;
  logic              w_dz;
  logic [SIZE-1:0]   w_res_hi;
  logic [SIZE-1:0]   w_res_lo;
  assign w_prod_n = ~{r_wh, r_wl} + 1'b1;

  always_comb begin
    w_neg_q  = r_op[0] & (r_a[M] ^ r_b[M]);
    w_neg_r  = r_op[0] & r_a[M];
    w_dz     = r_op[1] & (r_b == '0);
    w_res_hi = r_wh;
    w_res_lo = r_wl;
    if (!r_op[1]) begin
      if (w_neg_q) begin
        w_res_hi = w_prod_n[2*SIZE-1:SIZE];
        w_res_lo = w_prod_n[SIZE-1:0];
      end
    end else if (w_dz) begin
      w_res_hi = r_a;
      w_res_lo = '1;
    end else begin
      if (w_neg_q) w_res_lo = ~r_wl + 1'b1;
      if (w_neg_r) w_res_hi = ~r_wh + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_m     <= '0;
      r_wh    <= '0;
      r_wl    <= '0;
      r_cnt   <= '0;
      r_f     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_zf    <= 1'b0;
      r_cf    <= 1'b0;
      r_of    <= 1'b0;
      r_sf    <= 1'b0;
      r_pf    <= 1'b0;
      r_dz    <= 1'b0;
      r_ovld  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op <= OP;
            r_a  <= A;
            r_b  <= B;
            if (OP[3:2] == 2'b11) begin
              r_wh    <= '0;
              r_wl    <= w_am;
              r_m     <= w_bm;
              r_cnt   <= '0;
              r_state <= S_BUSY;
            end else begin
              r_state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          r_f     <= w_f;
          r_zf    <= ~w_rsv & (w_f == '0);
          r_cf    <= w_cf;
          r_of    <= w_of;
          r_sf    <= w_f[M];
          r_pf    <= ^w_f;
          r_ovld  <= 1'b1;
          r_state <= S_DONE;
        end
        S_BUSY: begin
          if (r_cnt == c_CNT_END) begin
            r_hi    <= w_res_hi;
            r_lo    <= w_res_lo;
            r_f     <= w_res_lo;
            r_zf    <= (w_res_lo == '0);
            r_cf    <= 1'b0;
            r_of    <= 1'b0;
            r_sf    <= w_res_lo[M];
            r_pf    <= ^w_res_lo;
            r_dz    <= w_dz;
            r_ovld  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            if (!r_op[1]) begin
              {r_wh, r_wl} <= {w_msum, r_wl[SIZE-1:1]};
            end else if (!w_rdif[SIZE]) begin
              r_wh <= w_rdif[SIZE-1:0];
              r_wl <= {r_wl[SIZE-2:0], 1'b1};
            end else begin
              r_wh <= w_rsh[SIZE-1:0];
              r_wl <= {r_wl[SIZE-2:0], 1'b0};
            end
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_ovld  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iter_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_iter_alu
// Brief    : Directed self-checking bench for iter_alu (SIZE = 32).
// Revision : 1.0  initial release
// ============================================================================
module tb_iter_alu;

  localparam logic [3:0] c_ADD  = 4'b0100;
  localparam logic [3:0] c_SUB  = 4'b0101;
  localparam logic [3:0] c_SLT  = 4'b0110;
  localparam logic [3:0] c_SLL  = 4'b0111;
  localparam logic [3:0] c_SLTU = 4'b1000;
  localparam logic [3:0] c_SRL  = 4'b1001;
  localparam logic [3:0] c_SRA  = 4'b1010;
  localparam logic [3:0] c_RSV  = 4'b1011;
  localparam logic [3:0] c_XOR  = 4'b0010;
  localparam logic [3:0] c_MULU = 4'b1100;
  localparam logic [3:0] c_MUL  = 4'b1101;
  localparam logic [3:0] c_DIVU = 4'b1110;
  localparam logic [3:0] c_DIV  = 4'b1111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  OP = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        in_ready, out_valid;
  logic [31:0] F, HI, LO;
  logic        ZF, CF, OF, SF, PF, DZ;

  int n_total = 0;
  int n_bad   = 0;
  int cyc;

  always #5 clk = ~clk;

  iter_alu #(.SIZE(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .OP(OP), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .F(F), .HI(HI), .LO(LO), .ZF(ZF), .CF(CF), .OF(OF), .SF(SF), .PF(PF),
    .DZ(DZ)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {ZF,CF,OF,SF,PF}
  function automatic logic [31:0] flg();
    return {27'd0, ZF, CF, OF, SF, PF};
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) chk("issue_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1; OP = op; A = a; B = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    OP = 4'($urandom); A = $urandom; B = $urandom;
  endtask

  task automatic wait_res(output int c);
    c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (!out_valid && c < 100);
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("take_vld", 32'(out_valid), 32'd0);
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input int lat);
    issue(op, a, b);
    wait_res(cyc);
    chk({tag, "_lat"}, cyc, lat);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_f", F, 32'd0);
    chk("rst_hilo", HI | LO, 32'd0);
    chk("rst_flags", flg() | 32'(DZ), 32'd0);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    run("add_ovf", c_ADD, 32'h7FFFFFFF, 32'h1, 1);
    chk("add_ovf_f", F, 32'h80000000); chk("add_ovf_fl", flg(), 32'h07); take();
    run("add_cy", c_ADD, 32'hFFFFFFFF, 32'h1, 1);
    chk("add_cy_f", F, 32'h0); chk("add_cy_fl", flg(), 32'h18); take();
    run("sub", c_SUB, 32'd3, 32'd5, 1);
    chk("sub_f", F, 32'hFFFFFFFE); chk("sub_fl", flg(), 32'h0B); take();
    run("slt", c_SLT, 32'hFFFFFFFF, 32'h1, 1);
    chk("slt_f", F, 32'h1); chk("slt_fl", flg(), 32'h01); take();
    run("sltu", c_SLTU, 32'hFFFFFFFF, 32'h1, 1);
    chk("sltu_f", F, 32'h0); chk("sltu_fl", flg(), 32'h10); take();
    run("sll", c_SLL, 32'h1, 32'h80000001, 1);
    chk("sll_f", F, 32'h2); chk("sll_fl", flg(), 32'h09); take();
    run("sra", c_SRA, 32'h4, 32'h80000000, 1);
    chk("sra_f", F, 32'hF8000000); chk("sra_fl", flg(), 32'h03); take();
    run("srl", c_SRL, 32'h4, 32'h80000000, 1);
    chk("srl_f", F, 32'h08000000); chk("srl_fl", flg(), 32'h01); take();
    run("rsv", c_RSV, 32'h5, 32'h6, 1);
    chk("rsv_f", F, 32'h0); chk("rsv_fl", flg(), 32'h00); take();

    run("mult", c_MUL, 32'hFFFFFFFD, 32'd7, 33);
    chk("mult_hi", HI, 32'hFFFFFFFF); chk("mult_lo", LO, 32'hFFFFFFEB);
    chk("mult_f", F, 32'hFFFFFFEB); chk("mult_fl", flg(), 32'h02); take();
    run("hold", c_ADD, 32'd1, 32'd1, 1);
    chk("hold_hi", HI, 32'hFFFFFFFF); chk("hold_lo", LO, 32'hFFFFFFEB); take();
    run("multu", c_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    chk("multu_hi", HI, 32'hFFFFFFFE); chk("multu_lo", LO, 32'h1); take();

    run("div", c_DIV, 32'hFFFFFFF9, 32'd2, 33);
    chk("div_lo", LO, 32'hFFFFFFFD); chk("div_hi", HI, 32'hFFFFFFFF);
    chk("div_dz", 32'(DZ), 32'd0); chk("div_fl", flg(), 32'h03); take();
    run("divu", c_DIVU, 32'd100, 32'd7, 33);
    chk("divu_lo", LO, 32'd14); chk("divu_hi", HI, 32'd2); take();
    run("dz", c_DIVU, 32'd7, 32'd0, 33);
    chk("dz_lo", LO, 32'hFFFFFFFF); chk("dz_hi", HI, 32'd7); chk("dz_dz", 32'(DZ), 32'd1); take();
    run("dz_keep", c_SUB, 32'd9, 32'd4, 1);
    chk("dz_keep_f", F, 32'd5); chk("dz_keep_dz", 32'(DZ), 32'd1); take();
    run("mneg", c_DIV, 32'h80000000, 32'hFFFFFFFF, 33);
    chk("mneg_lo", LO, 32'h80000000); chk("mneg_hi", HI, 32'h0);
    chk("mneg_dz", 32'(DZ), 32'd0); take();

    // Backpressure: result must hold while a new request is presented.
    run("xor", c_XOR, 32'h0000F0F0, 32'h00000FF0, 1);
    chk("xor_f", F, 32'h0000FF00);
    @(negedge clk);
    in_valid = 1'b1; OP = c_ADD; A = 32'd1; B = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_rdy", 32'(in_ready), 32'd0);
      chk("bp_vld", 32'(out_valid), 32'd1);
      chk("bp_f", F, 32'h0000FF00);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("rel_vld", 32'(out_valid), 32'd0);
    chk("rel_rdy", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("acc_rdy", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_next_vld", 32'(out_valid), 32'd1);
    chk("bp_next_f", F, 32'd2);
    take();

    // Reset in the middle of an iterative operation.
    run("pre", c_MULU, 32'h10, 32'h20, 33);
    chk("pre_lo", LO, 32'h200); take();
    issue(c_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_vld", 32'(out_valid), 32'd0);
    chk("mrst_hilo", HI | LO, 32'd0);
    chk("mrst_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("mrst_novld", 32'(out_valid), 32'd0);
    run("post", c_ADD, 32'd2, 32'd3, 1);
    chk("post_f", F, 32'd5); take();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
